// File: rtl/pe_pkg.sv
// Shared PE datapath definitions: bf16 field widths, common bf16 constants,
// and the accumulator FSM state encoding.
package pe_pkg;
   localparam int BF16_EXP_BIT = 8;
   localparam int BF16_MAT_BIT = 7;

   localparam logic [15:0] BF16_ZERO = 16'h0000;
   localparam logic [15:0] BF16_ONE  = 16'h3F80;

   localparam logic [0:0] S_ACC = 1'b0;   // accumulating a vector
   localparam logic [0:0] S_OUT = 1'b1;   // result held for downstream
endpackage

// File: rtl/add_fp.sv
// add_fp: bf16-style floating-point adder, round-to-nearest-even, gradual
// underflow, IEEE special values (canonical quiet NaN).
// Ports:
//   clk, rst     clock / async active-low reset (used only for the optional
//                output register)
//   in_a, in_b   operands
//   out_sum      sum; combinational when ENABLE_PIPELINE=0, registered otherwise
module add_fp #(
   parameter int EXP_BIT         = 8,
   parameter int MAT_BIT         = 7,
   parameter int DATA_BIT        = 16,
   parameter int ENABLE_PIPELINE = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_BIT-1:0] in_a,
   input  logic [DATA_BIT-1:0] in_b,
   output logic [DATA_BIT-1:0] out_sum
);
   localparam int XW = MAT_BIT + 4;   // hidden + fraction + guard/round/sticky
   localparam int SW = XW + 1;        // plus carry
   localparam int EW = EXP_BIT + 2;   // headroom for exponent arithmetic

   logic [DATA_BIT-1:0] big, sml, sum_c, sum_q;
   logic [EXP_BIT-1:0]  eb_raw, es_raw;
   logic [EW-1:0]       e_big, e_sml, e_res, diff;
   logic [XW-1:0]       m_big, m_sml, m_sh, norm;
   logic [SW-1:0]       s;
   logic [MAT_BIT+1:0]  rnd;
   logic                sticky, sub, rup, a_nan, b_nan, a_inf, b_inf;
   int                  lz, sh;

   always_comb begin
      // order operands by magnitude so the result sign comes from 'big'
      if (in_a[DATA_BIT-2:0] >= in_b[DATA_BIT-2:0]) begin
         big = in_a; sml = in_b;
      end else begin
         big = in_b; sml = in_a;
      end
      eb_raw = big[DATA_BIT-2 -: EXP_BIT];
      es_raw = sml[DATA_BIT-2 -: EXP_BIT];
      // subnormals use exponent 1 with hidden bit 0
      e_big  = (eb_raw == '0) ? EW'(1) : EW'(eb_raw);
      e_sml  = (es_raw == '0) ? EW'(1) : EW'(es_raw);
      m_big  = {|eb_raw, big[MAT_BIT-1:0], 3'b000};
      m_sml  = {|es_raw, sml[MAT_BIT-1:0], 3'b000};
      diff   = e_big - e_sml;

      sticky = 1'b0;
      if (diff >= EW'(XW)) begin
         m_sh   = '0;
         sticky = |m_sml;
      end else begin
         for (int i = 0; i < XW; i++)
            if (i < int'(diff)) sticky = sticky | m_sml[i];
         m_sh = m_sml >> diff;
      end
      m_sh[0] = m_sh[0] | sticky;

      sub = big[DATA_BIT-1] ^ sml[DATA_BIT-1];
      s   = sub ? ({1'b0, m_big} - {1'b0, m_sh}) : ({1'b0, m_big} + {1'b0, m_sh});

      lz = XW;
      sh = 0;
      if (s[SW-1]) begin
         norm    = s[XW:1];
         norm[0] = norm[0] | s[0];
         e_res   = e_big + EW'(1);
      end else begin
         for (int i = 0; i < XW; i++)
            if (s[i]) lz = XW - 1 - i;
         // never shift below exponent 1: that is where subnormals live
         sh = (lz > int'(e_big) - 1) ? int'(e_big) - 1 : lz;
         norm  = s[XW-1:0] << sh;
         e_res = e_big - EW'(sh);
         if (!norm[XW-1]) e_res = '0;
      end

      rup = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd = {1'b0, norm[XW-1:3]} + (MAT_BIT+2)'(rup);
      if (rnd[MAT_BIT+1]) begin
         e_res = e_res + EW'(1);
         rnd   = rnd >> 1;
      end
      if (e_res == '0 && rnd[MAT_BIT]) e_res = EW'(1);   // rounded up into normal range

      if (e_res >= EW'((1 << EXP_BIT) - 1))
         sum_c = {big[DATA_BIT-1], {EXP_BIT{1'b1}}, {MAT_BIT{1'b0}}};
      else
         sum_c = {big[DATA_BIT-1], e_res[EXP_BIT-1:0], rnd[MAT_BIT-1:0]};

      // exact cancellation gives +0; -0 + -0 stays -0
      if (s == '0)
         sum_c = {big[DATA_BIT-1] & sml[DATA_BIT-1], {(DATA_BIT-1){1'b0}}};

      a_nan = (&in_a[DATA_BIT-2 -: EXP_BIT]) & (|in_a[MAT_BIT-1:0]);
      b_nan = (&in_b[DATA_BIT-2 -: EXP_BIT]) & (|in_b[MAT_BIT-1:0]);
      a_inf = (&in_a[DATA_BIT-2 -: EXP_BIT]) & ~(|in_a[MAT_BIT-1:0]);
      b_inf = (&in_b[DATA_BIT-2 -: EXP_BIT]) & ~(|in_b[MAT_BIT-1:0]);
      if (a_nan | b_nan | (a_inf & b_inf & sub))
         sum_c = {1'b0, {EXP_BIT{1'b1}}, 1'b1, {(MAT_BIT-1){1'b0}}};
      else if (a_inf | b_inf)
         sum_c = big;   // the infinity always sorts as the larger operand
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sum_q <= '0;
      else      sum_q <= sum_c;
   end

   assign out_sum = (ENABLE_PIPELINE != 0) ? sum_q : sum_c;
endmodule

// File: rtl/fp_acc_stream.sv
// fp_acc_stream: streaming bf16 accumulator. Sums each in_last-delimited
// vector of products and emits one registered result per vector.
// Ports:
//   clk, rst                         clock / async active-low reset
//   in_valid, in_ready, in_data,
//   in_last                          product stream (valid/ready)
//   out_valid, out_ready             result handshake
//   out_data                         accumulated sum
//   out_count                        beats summed (1..MAX_LEN)
//   out_trunc                        vector force-closed at MAX_LEN
module fp_acc_stream
   import pe_pkg::*;
#(
   parameter int EXP_BIT  = BF16_EXP_BIT,
   parameter int MAT_BIT  = BF16_MAT_BIT,
   parameter int DATA_BIT = 16,
   parameter int MAX_LEN  = 256,
   localparam int CNT_BIT = $clog2(MAX_LEN) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_BIT-1:0] in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_BIT-1:0] out_data,
   output logic [CNT_BIT-1:0]  out_count,
   output logic                out_trunc
);
   logic [0:0]          state;
   logic [DATA_BIT-1:0] acc, add_sum, new_sum;
   logic [CNT_BIT-1:0]  cnt;
   logic                first, accept, closing;

   // single-cycle adder keeps the acc feedback loop hazard-free
   add_fp #(
      .EXP_BIT(EXP_BIT), .MAT_BIT(MAT_BIT), .DATA_BIT(DATA_BIT), .ENABLE_PIPELINE(0)
   ) u_add (
      .clk(clk), .rst(rst), .in_a(acc), .in_b(in_data), .out_sum(add_sum)
   );

   // a held result drains in the same cycle a new beat is taken: no bubble
   assign in_ready = (state == S_ACC) | ((state == S_OUT) & out_ready);
   assign accept   = in_valid & in_ready;
   // first beat bypasses the adder so its sign (incl. -0) is kept verbatim
   assign new_sum  = first ? in_data : add_sum;
   assign closing  = accept & (in_last | (cnt == CNT_BIT'(MAX_LEN - 1)));
   assign out_valid = (state == S_OUT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_ACC;
         acc       <= DATA_BIT'(BF16_ZERO);
         cnt       <= '0;
         first     <= 1'b1;
         out_data  <= '0;
         out_count <= '0;
         out_trunc <= 1'b0;
      end else begin
         if (closing) begin
            state     <= S_OUT;
            out_data  <= new_sum;
            out_count <= cnt + CNT_BIT'(1);
            out_trunc <= ~in_last;
            acc       <= DATA_BIT'(BF16_ZERO);
            cnt       <= '0;
            first     <= 1'b1;
         end else begin
            if (accept) begin
               acc   <= new_sum;
               cnt   <= cnt + CNT_BIT'(1);
               first <= 1'b0;
            end
            if ((state == S_OUT) && out_ready) state <= S_ACC;
         end
      end
   end
endmodule

// File: tb/tb_fp_acc_stream.sv
module tb_fp_acc_stream;
   localparam int DW = 16;
   localparam int ML = 4;
   localparam int CW = $clog2(ML) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_last, out_valid, out_ready, out_trunc;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] out_count;

   int n_tests = 0;
   int n_fail  = 0;

   fp_acc_stream #(.EXP_BIT(8), .MAT_BIT(7), .DATA_BIT(DW), .MAX_LEN(ML)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_trunc(out_trunc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        ov;      // expected out_valid after this beat's edge
      logic [15:0] sum;
      logic [2:0]  cnt;
      logic        trunc;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [15:0] sum, input logic [2:0] cnt,
                          input logic trunc);
      chk({name, ".valid"}, 32'(out_valid), 32'd1);
      chk({name, ".data"},  32'(out_data),  32'(sum));
      chk({name, ".count"}, 32'(out_count), 32'(cnt));
      chk({name, ".trunc"}, 32'(out_trunc), 32'(trunc));
   endtask

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{16'h3F80, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
      tbl[1]  = '{16'h4000, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
      tbl[2]  = '{16'h4040, 1'b1, 1'b1, 16'h40C0, 3'd3, 1'b0};  // 1+2+3
      tbl[3]  = '{16'h4000, 1'b1, 1'b1, 16'h4000, 3'd1, 1'b0};  // back-to-back
      tbl[4]  = '{16'h4040, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
      tbl[5]  = '{16'h4040, 1'b1, 1'b1, 16'h40C0, 3'd2, 1'b0};  // 3+3
      tbl[6]  = '{16'h3F80, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
      tbl[7]  = '{16'h3F80, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
      tbl[8]  = '{16'h3F80, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
      tbl[9]  = '{16'h3F80, 1'b0, 1'b1, 16'h4080, 3'd4, 1'b1};  // forced at MAX_LEN
      tbl[10] = '{16'h3F80, 1'b1, 1'b1, 16'h3F80, 3'd1, 1'b0};
      tbl[11] = '{16'hBF80, 1'b1, 1'b1, 16'hBF80, 3'd1, 1'b0};  // sign kept
      tbl[12] = '{16'h3F80, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
      tbl[13] = '{16'hBF80, 1'b1, 1'b1, 16'h0000, 3'd2, 1'b0};  // cancel to +0

      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
      step(); step();
      chk("reset.valid", 32'(out_valid), 32'd0);
      chk("reset.data",  32'(out_data),  32'd0);
      chk("reset.count", 32'(out_count), 32'd0);
      chk("reset.trunc", 32'(out_trunc), 32'd0);
      chk("reset.ready", 32'(in_ready),  32'd1);
      rst = 1'b1;
      step();

      // continuous stream, out_ready high: in_ready must never drop
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1; in_data = tbl[i].data; in_last = tbl[i].last;
         #1;
         chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
         step();
         if (tbl[i].ov) chk_out($sformatf("vec%0d", i), tbl[i].sum, tbl[i].cnt, tbl[i].trunc);
         else           chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      step();
      chk("drain.valid", 32'(out_valid), 32'd0);

      // backpressure: result held while out_ready=0, next vector stalled
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 16'h3F80; in_last = 1'b0; step();
      in_data = 16'h4000; in_last = 1'b0; step();
      in_data = 16'h4040; in_last = 1'b1; step();
      in_data = 16'h4000; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 32'd0);
         chk_out($sformatf("bp%0d", c), 16'h40C0, 3'd3, 1'b0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release.in_ready", 32'(in_ready), 32'd1);
      step();
      chk_out("bp_next", 16'h4000, 3'd1, 1'b0);
      in_valid = 1'b0; in_last = 1'b0;
      step();
      chk("bp_done.valid", 32'(out_valid), 32'd0);

      // reset with a partial vector and a stale result register
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h3F80; in_last = 1'b1; step();
      out_ready = 1'b1; in_data = 16'h4000; in_last = 1'b0; step();
      in_data = 16'h4000; step();
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("midrst.valid", 32'(out_valid), 32'd0);
      chk("midrst.data",  32'(out_data),  32'd0);
      chk("midrst.count", 32'(out_count), 32'd0);
      #1 rst = 1'b1;
      step();

      // in_last without in_valid is ignored
      in_valid = 1'b0; in_last = 1'b1; in_data = 16'h4040; step();
      chk("lastnovalid.valid", 32'(out_valid), 32'd0);

      in_valid = 1'b1; in_data = 16'h3F80; in_last = 1'b1; step();
      chk_out("postrst", 16'h3F80, 3'd1, 1'b0);
      in_valid = 1'b0; in_last = 1'b0; step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
